a1_vector_sequencer: RTL and testbench

Upstream stimulus stage for the 3-input combinational A1 block. It drives the A1 select input i through all 8 codes, 000 to 111, holding each code for a programmable number of cycles. It samples A1's output f once per code and builds an 8-bit captured truth table. At the end of a pass it compares the table against an expected table and reports pass/fail plus the first mismatching index.

---
 rtl/a1_vector_sequencer.sv | 111 +++++++++++
 tb/tb_a1_vector_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/a1_vector_sequencer.sv
// Walks A1's select input i through codes 0..7, captures f once per code, and grades the table against exp.
// Latency: done pulses 8*HOLD_CYCLES+1 cycles after the edge that accepts start.
// Backpressure: none; start is ignored while busy, and abort ends a run on the next edge.
module a1_vector_sequencer #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SAMPLE_OFFSET = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic [7:0] exp,
    input  logic       f,
    output logic [2:0] i,
    output logic [7:0] tt,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err,
    output logic [2:0] err_idx
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] CNT_SAMP = 8'(SAMPLE_OFFSET);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] work;
    logic [7:0] exp_q;
    logic       match;
    logic [2:0] miss_idx;

    assign match = (work == exp_q);

    // Scan from the top down so the lowest mismatching index wins.
    always_comb begin
        miss_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (work[k] != exp_q[k]) miss_idx = 3'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            work    <= 8'd0;
            exp_q   <= 8'd0;
            i       <= 3'd0;
            tt      <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err     <= 1'b0;
            err_idx <= 3'd0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Results of the previous pass stay visible.
                state <= IDLE;
                i     <= 3'd0;
                busy  <= 1'b0;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        i <= 3'd0;
                        if (start) begin
                            exp_q <= exp;
                            work  <= 8'd0;
                            cnt   <= 8'd0;
                            busy  <= 1'b1;
                            state <= APPLY;
                        end
                    end
                    APPLY: begin
                        if (cnt == CNT_SAMP) work[i] <= f;
                        if (cnt == CNT_LAST) begin
                            cnt <= 8'd0;
                            if (i == 3'd7) state <= CHECK;
                            else           i     <= i + 3'd1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    CHECK: begin
                        tt      <= work;
                        pass    <= match;
                        err     <= ~match;
                        err_idx <= match ? 3'd0 : miss_idx;
                        done    <= 1'b1;
                        i       <= 3'd0;
                        if (cont) begin
                            work  <= 8'd0;
                            cnt   <= 8'd0;
                            state <= APPLY;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a1_vector_sequencer.sv
// Directed bench for a1_vector_sequencer: expected pass results are queued at stimulus time
// and a negedge monitor grades each done pulse against them.
module tb_a1_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       abort;
    logic [7:0] exp_r;
    logic       f;
    logic [2:0] i;
    logic [7:0] tt;
    logic       busy;
    logic       done;
    logic       pass;
    logic       err;
    logic [2:0] err_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int fmode  = 0;

    typedef struct packed {
        logic [7:0] tt;
        logic       pass;
        logic       err;
        logic [2:0] idx;
    } res_t;

    res_t sb[$];

    a1_vector_sequencer #(.HOLD_CYCLES(4), .SAMPLE_OFFSET(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cont    (cont),
        .abort   (abort),
        .exp     (exp_r),
        .f       (f),
        .i       (i),
        .tt      (tt),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err     (err),
        .err_idx (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of A1: 0 = majority(i), 1 = constant 0, 2 = i[0].
    always_comb begin
        case (fmode)
            0:       f = (i[0] & i[1]) | (i[0] & i[2]) | (i[1] & i[2]);
            1:       f = 1'b0;
            default: f = i[0];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [7:0] t, input logic p, input logic e, input logic [2:0] x);
        res_t r;
        r.tt   = t;
        r.pass = p;
        r.err  = e;
        r.idx  = x;
        sb.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge 0, the edge that accepts start.
    task automatic begin_run(input logic [7:0] e);
        exp_r = e;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        step();
    endtask

    always @(negedge clk) begin : monitor
        res_t r;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pass expected at %0t", $time);
            end else begin
                r = sb.pop_front();
                chk("sb_tt", 32'(tt), 32'(r.tt));
                chk("sb_pass", 32'(pass), 32'(r.pass));
                chk("sb_err", 32'(err), 32'(r.err));
                chk("sb_err_idx", 32'(err_idx), 32'(r.idx));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        abort = 1'b0;
        exp_r = 8'h00;
        #12;
        chk("rst_i", 32'(i), 32'd0);
        chk("rst_tt", 32'(tt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass_err", {29'd0, pass, err, 1'b0}, 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        rst_n = 1'b1;
        step();

        // Single pass with majority, start re-pulsed and exp changed mid-run.
        fmode = 0;
        push(8'hE8, 1'b1, 1'b0, 3'd0);
        begin_run(8'hE8);
        chk("p1_i_e0", 32'(i), 32'd0);
        chk("p1_busy_e0", 32'(busy), 32'd1);
        for (int e = 1; e <= 34; e++) begin
            if (e == 12) start = 1'b1;
            if (e == 6)  exp_r = 8'h00;
            step();
            start = 1'b0;
            if (e % 4 == 0 && e < 32) chk("p1_i_step", 32'(i), 32'(e / 4));
            if (e == 31) chk("p1_i_e31", 32'(i), 32'd7);
            if (e == 32) begin
                chk("p1_done_e32", 32'(done), 32'd0);
                chk("p1_i_e32", 32'(i), 32'd7);
                chk("p1_busy_e32", 32'(busy), 32'd1);
            end
            if (e == 33) begin
                chk("p1_done_e33", 32'(done), 32'd1);
                chk("p1_busy_e33", 32'(busy), 32'd0);
                chk("p1_i_e33", 32'(i), 32'd0);
            end
            if (e == 34) chk("p1_done_e34", 32'(done), 32'd0);
        end

        // Mismatch reporting.
        push(8'hE8, 1'b0, 1'b1, 3'd0);
        begin_run(8'hE9);
        wait_done("mm_e9_done");
        push(8'hE8, 1'b0, 1'b1, 3'd6);
        begin_run(8'hA8);
        wait_done("mm_a8_done");

        // Abort at edge 10: no done, results retained.
        fmode = 1;
        begin_run(8'hE8);
        for (int e = 1; e <= 10; e++) begin
            if (e == 10) abort = 1'b1;
            step();
            abort = 1'b0;
        end
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_i", 32'(i), 32'd0);
        repeat (40) step();
        chk("ab_tt", 32'(tt), 32'hE8);
        chk("ab_err_idx", 32'(err_idx), 32'd6);
        chk("ab_err", 32'(err), 32'd1);

        // start together with abort in IDLE is refused.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        step();
        chk("sa_busy2", 32'(busy), 32'd0);

        // Continuous mode, cont dropped between the 2nd and 3rd CHECK.
        fmode = 2;
        cont  = 1'b1;
        push(8'hAA, 1'b1, 1'b0, 3'd0);
        push(8'hAA, 1'b1, 1'b0, 3'd0);
        push(8'hAA, 1'b1, 1'b0, 3'd0);
        begin_run(8'hAA);
        for (int e = 1; e <= 134; e++) begin
            if (e == 67) cont = 1'b0;
            step();
            if (e == 32 || e == 65 || e == 98) chk("ct_done_low", 32'(done), 32'd0);
            if (e == 33 || e == 66 || e == 99) chk("ct_done_high", 32'(done), 32'd1);
            if (e == 66) chk("ct_busy_e66", 32'(busy), 32'd1);
            if (e == 99) chk("ct_busy_e99", 32'(busy), 32'd0);
            if (e == 134) chk("ct_busy_end", 32'(busy), 32'd0);
        end

        // Asynchronous reset mid-run at i=5.
        fmode = 0;
        begin_run(8'hE8);
        repeat (20) step();
        chk("mr_i_before", 32'(i), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_i", 32'(i), 32'd0);
        chk("mr_tt", 32'(tt), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_flags", {28'd0, done, pass, err, 1'b0}, 32'd0);
        chk("mr_err_idx", 32'(err_idx), 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (40) step();
        chk("mr_idle_busy", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
